mux_rr_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one 16-bit 2:1 datapath mux between two valid/ready requesters. It picks a winner each cycle, drives the mux select, and registers the selected word into a single-entry output stage with valid/ready handshake. It sits in front of shared processor resources, such as a write-back or memory port, where two producers compete for one 16-bit path.

---
 rtl/mux_arb_pkg.sv | 19 +
 rtl/mux_rr_arbiter_mux2.sv | 13 +
 rtl/mux_rr_arbiter.sv | 160 ++++++++++++++++
 tb/tb_mux_rr_arbiter.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_arb_pkg.sv
// Shared types and defaults for the mux_rr_arbiter block.
// The lock FSM states are only reachable when BURST_LOCK_EN is defined.
package mux_arb_pkg;

  typedef enum logic [1:0] {
    ARB   = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } arb_state_t;

  localparam int DEFAULT_WIDTH     = 16;
  localparam int DEFAULT_MAX_BURST = 4;

  // Burst counter must be able to hold the value MAX_BURST itself.
  function automatic int burst_cnt_width(input int max_burst);
    return $clog2(max_burst + 1);
  endfunction

endpackage

// File: rtl/mux_rr_arbiter_mux2.sv
// Plain 2:1 datapath mux shared between the two requesters.
module mux_rr_arbiter_mux2 #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             sel_i,
  output logic [WIDTH-1:0] y_o
);

  assign y_o = sel_i ? b_i : a_i;

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter in front of a shared 16-bit 2:1 mux, with a
// single-entry registered output stage (valid/ready).
// Optional build macro BURST_LOCK_EN adds in0_lock/in1_lock ports and a
// burst-lock FSM (ARB, LOCK0, LOCK1) bounded by MAX_BURST beats.
module mux_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
`ifdef BURST_LOCK_EN
  ,
  parameter int MAX_BURST = DEFAULT_MAX_BURST
`endif
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in0_valid,
  input  logic [WIDTH-1:0] in0_data,
  output logic             in0_ready,
  input  logic             in1_valid,
  input  logic [WIDTH-1:0] in1_data,
  output logic             in1_ready,
`ifdef BURST_LOCK_EN
  input  logic             in0_lock,
  input  logic             in1_lock,
`endif
  output logic             sel,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready
);

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             prio_q, prio_d;

  logic             load_en;
  logic             grant;
  logic             xfer;
  logic [WIDTH-1:0] mux_y;
  arb_state_t       state_cur;

`ifdef BURST_LOCK_EN
  localparam int CNT_W = burst_cnt_width(MAX_BURST);

  arb_state_t       state_q, state_d;
  logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;
  logic             lock_g;

  assign state_cur = state_q;
`else
  assign state_cur = ARB;
`endif

  // Output slot can accept a new word while it drains in the same cycle.
  assign load_en = !out_valid_q || out_ready;

  // Winner selection: locked owner, else single requester, else priority.
  // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
  always_comb begin
    grant = prio_q;
    case (state_cur)
      LOCK0:   grant = 1'b0;
      LOCK1:   grant = 1'b1;
      default: begin
        if (in0_valid && in1_valid) grant = prio_q;
        else if (in0_valid)         grant = 1'b0;
        else if (in1_valid)         grant = 1'b1;
      end
    endcase
  end

  assign sel       = grant;
  assign in0_ready = load_en && !grant && in0_valid;
  assign in1_ready = load_en &&  grant && in1_valid;
  assign xfer      = in0_ready || in1_ready;

  mux_rr_arbiter_mux2 #(
    .WIDTH (WIDTH)
  ) u_mux (
    .a_i   (in0_data),
    .b_i   (in1_data),
    .sel_i (grant),
    .y_o   (mux_y)
  );

  // Output stage and round-robin priority next state.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    prio_d      = prio_q;
    if (xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = mux_y;
      prio_d      = !grant;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Output register and priority flop; reset discards any pending word.
  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      prio_q      <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      prio_q      <= prio_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

`ifdef BURST_LOCK_EN
  assign lock_g = grant ? in1_lock : in0_lock;

  // Lock FSM next state: enter on a locked transfer, leave on unlock or at MAX_BURST.
  always_comb begin
    state_d     = state_q;
    burst_cnt_d = burst_cnt_q;
    case (state_q)
      ARB: begin
        if (xfer && lock_g && (MAX_BURST > 1)) begin
          state_d     = grant ? LOCK1 : LOCK0;
          burst_cnt_d = CNT_W'(1);
        end
      end
      LOCK0, LOCK1: begin
        if (xfer) begin
          if (!lock_g || (burst_cnt_q == CNT_W'(MAX_BURST - 1))) begin
            state_d     = ARB;
            burst_cnt_d = '0;
          end else begin
            burst_cnt_d = burst_cnt_q + CNT_W'(1);
          end
        end
      end
      default: begin
        state_d     = ARB;
        burst_cnt_d = '0;
      end
    endcase
  end

  // Lock FSM state and burst counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ARB;
      burst_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end
`endif

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Self-checking bench for mux_rr_arbiter with a scoreboard of expected words.
// Lock scenarios are compiled only when BURST_LOCK_EN is defined.
module tb_mux_rr_arbiter;
  import mux_arb_pkg::*;

  localparam int W         = 16;
  localparam int MAX_BURST = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          in0_valid = 1'b0, in1_valid = 1'b0;
  logic [W-1:0]  in0_data = '0, in1_data = '0;
  logic          in0_ready, in1_ready;
  logic          lk0 = 1'b0, lk1 = 1'b0;
  logic          sel;
  logic          out_valid;
  logic [W-1:0]  out_data;
  logic          out_ready = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  // Scoreboard, drained words, and grants observed on transfers.
  logic [W-1:0] sb[$];
  logic [W-1:0] drained[$];
  logic         grants[$];

  // Reference model state.
  logic       m_out_valid;
  logic       m_prio;
  arb_state_t m_state;
  int         m_cnt;

  logic last_sel, last_rdy0, last_rdy1;

  always #5 clk = ~clk;

  mux_rr_arbiter #(
    .WIDTH     (W)
`ifdef BURST_LOCK_EN
    ,
    .MAX_BURST (MAX_BURST)
`endif
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in0_valid (in0_valid),
    .in0_data  (in0_data),
    .in0_ready (in0_ready),
    .in1_valid (in1_valid),
    .in1_data  (in1_data),
    .in1_ready (in1_ready),
`ifdef BURST_LOCK_EN
    .in0_lock  (lk0),
    .in1_lock  (lk1),
`endif
    .sel       (sel),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Apply reset from the current time; checks hold without any clock edge.
  task automatic do_reset();
    in0_valid = 1'b0; in1_valid = 1'b0; out_ready = 1'b0;
    lk0 = 1'b0; lk1 = 1'b0;
    reset = 1'b1;
    #1;
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_out_data",  {16'b0, out_data},  32'd0);
    check("rst_sel",       {31'b0, sel},       32'd0);
    check("rst_readies",   {30'b0, in1_ready, in0_ready}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    m_out_valid = 1'b0; m_prio = 1'b0; m_state = ARB; m_cnt = 0;
    sb.delete(); drained.delete(); grants.delete();
  endtask

  // One cycle: drive at negedge, check combinational and registered outputs,
  // update scoreboard, clock, then advance the model.
  task automatic step(input logic v0, input logic [W-1:0] d0,
                      input logic v1, input logic [W-1:0] d1, input logic ordy);
    logic g, l, x, lock_g;
    in0_valid = v0; in0_data = d0;
    in1_valid = v1; in1_data = d1;
    out_ready = ordy;
    #1;
    l = !m_out_valid || ordy;
    if (m_state == LOCK0)      g = 1'b0;
    else if (m_state == LOCK1) g = 1'b1;
    else if (v0 && v1)         g = m_prio;
    else if (v0)               g = 1'b0;
    else if (v1)               g = 1'b1;
    else                       g = m_prio;
    x = l && (g ? v1 : v0);
    last_sel = sel; last_rdy0 = in0_ready; last_rdy1 = in1_ready;
    check("sel",       {31'b0, sel},       {31'b0, g});
    check("in0_ready", {31'b0, in0_ready}, {31'b0, l && !g && v0});
    check("in1_ready", {31'b0, in1_ready}, {31'b0, l && g && v1});
    check("out_valid", {31'b0, out_valid}, {31'b0, m_out_valid});
    if (out_valid) begin
      check("sb_level", {31'b0, sb.size() != 0}, 32'd1);
      if (sb.size() != 0) begin
        check("out_data", {16'b0, out_data}, {16'b0, sb[0]});
        if (ordy) begin
          drained.push_back(out_data);
          void'(sb.pop_front());
        end
      end
    end
    if (in0_ready || in1_ready) grants.push_back(sel);
    if (x) sb.push_back(g ? d1 : d0);
    @(posedge clk);
    lock_g = g ? lk1 : lk0;
    if (x) begin
      m_out_valid = 1'b1;
      m_prio = !g;
`ifdef BURST_LOCK_EN
      if (m_state == ARB) begin
        if (lock_g && MAX_BURST > 1) begin
          m_state = g ? LOCK1 : LOCK0;
          m_cnt = 1;
        end
      end else begin
        m_cnt++;
        if (!lock_g || m_cnt == MAX_BURST) begin
          m_state = ARB;
          m_cnt = 0;
        end
      end
`endif
    end else if (ordy) begin
      m_out_valid = 1'b0;
    end
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] exp_alt[6];
    logic [W-1:0] n0, n1;
    exp_alt = '{16'hA000, 16'hB000, 16'hA001, 16'hB001, 16'hA002, 16'hB002};

    // Single word through in0, one-cycle latency.
    do_reset();
    step(1'b1, 16'h1234, 1'b0, 16'h0, 1'b1);
    check("t1_sel",  {31'b0, last_sel},  32'd0);
    check("t1_rdy0", {31'b0, last_rdy0}, 32'd1);
    check("t1_out_valid", {31'b0, out_valid}, 32'd1);
    check("t1_out_data",  {16'b0, out_data},  32'h1234);
    step(1'b0, 16'h0, 1'b0, 16'h0, 1'b1);

    // Both requesters continuously valid: grants alternate.
    do_reset();
    n0 = '0; n1 = '0;
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 16'hA000 + n0, 1'b1, 16'hB000 + n1, 1'b1);
      if (last_rdy0) n0++;
      if (last_rdy1) n1++;
    end
    step(1'b0, 16'h0, 1'b0, 16'h0, 1'b1);
    check("alt_count", drained.size(), 32'd6);
    for (int i = 0; i < 6; i++)
      if (i < drained.size()) check($sformatf("alt_word%0d", i), {16'b0, drained[i]}, {16'b0, exp_alt[i]});

    // Output stall: data held, readies low, reload in the draining cycle.
    do_reset();
    step(1'b0, 16'h0, 1'b1, 16'h00FF, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 16'h1111, 1'b0, 16'h0, 1'b0);
      check("stall_rdy0", {31'b0, last_rdy0}, 32'd0);
      check("stall_rdy1", {31'b0, last_rdy1}, 32'd0);
      check("stall_data", {16'b0, out_data}, 32'h00FF);
    end
    step(1'b1, 16'h1111, 1'b0, 16'h0, 1'b1);
    check("stall_release_rdy0", {31'b0, last_rdy0}, 32'd1);
    step(1'b0, 16'h0, 1'b0, 16'h0, 1'b1);
    check("stall_drain_cnt", drained.size(), 32'd2);
    if (drained.size() == 2) begin
      check("stall_drain0", {16'b0, drained[0]}, 32'h00FF);
      check("stall_drain1", {16'b0, drained[1]}, 32'h1111);
    end

    // Reset while holding a word: drops asynchronously, prio back to 0.
    step(1'b1, 16'hDEAD, 1'b0, 16'h0, 1'b0);
    check("pre_rst_valid", {31'b0, out_valid}, 32'd1);
    check("pre_rst_data",  {16'b0, out_data},  32'hDEAD);
    do_reset();
    step(1'b1, 16'h0A0A, 1'b1, 16'h0B0B, 1'b1);
    check("post_rst_sel", {31'b0, last_sel}, 32'd0);
    step(1'b0, 16'h0, 1'b0, 16'h0, 1'b1);

    // Only in1 valid with prio=0: granted at once, prio returns to 0.
    do_reset();
    step(1'b0, 16'h0, 1'b1, 16'h5555, 1'b1);
    check("in1_only_sel",  {31'b0, last_sel},  32'd1);
    check("in1_only_rdy1", {31'b0, last_rdy1}, 32'd1);
    step(1'b1, 16'h6666, 1'b1, 16'h7777, 1'b1);
    check("in1_only_next_sel", {31'b0, last_sel}, 32'd0);
    step(1'b0, 16'h0, 1'b0, 16'h0, 1'b1);

`ifdef BURST_LOCK_EN
    // Held lock: four in0 beats, forced release, then in1.
    do_reset();
    lk0 = 1'b1;
    n0 = '0; n1 = '0;
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 16'hC000 + n0, 1'b1, 16'hD000 + n1, 1'b1);
      if (last_rdy0) n0++;
      if (last_rdy1) n1++;
    end
    step(1'b0, 16'h0, 1'b0, 16'h0, 1'b1);
    check("lock_grants", grants.size(), 32'd6);
    if (grants.size() == 6)
      check("lock_seq", {26'b0, grants[0], grants[1], grants[2], grants[3], grants[4], grants[5]},
            32'b000010);

    // Lock dropped on beat 2: in1 granted on the next beat.
    do_reset();
    lk0 = 1'b1;
    step(1'b1, 16'hE000, 1'b1, 16'hF000, 1'b1);
    lk0 = 1'b0;
    step(1'b1, 16'hE001, 1'b1, 16'hF000, 1'b1);
    step(1'b1, 16'hE002, 1'b1, 16'hF000, 1'b1);
    step(1'b0, 16'h0, 1'b0, 16'h0, 1'b1);
    check("unlock_grants", grants.size(), 32'd3);
    if (grants.size() == 3)
      check("unlock_seq", {29'b0, grants[0], grants[1], grants[2]}, 32'b001);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
